branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 23 ++
 rtl/branch_predictor_sat_counter.sv | 25 ++
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared BTB definitions: field widths, counter constants and PC index/tag extraction,
// used by both the fetch-side lookup and the execute-side update.
package bp_defs;

    localparam int PC_W      = 32;
    localparam int TARGET_W  = 32;
    localparam int PC_ALIGN  = 2;   // instructions are word aligned; pc[1:0] never selects an entry
    localparam int CNT_RESET = 0;

    // Allocation value is weakly taken: only the counter MSB set.
    function automatic int cnt_alloc(int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic logic [PC_W-1:0] pc_index(logic [PC_W-1:0] pc, int idx_w);
        return (pc >> PC_ALIGN) & ((PC_W'(1) << idx_w) - PC_W'(1));
    endfunction

    function automatic logic [PC_W-1:0] pc_tag(logic [PC_W-1:0] pc, int idx_w);
        return pc >> (idx_w + PC_ALIGN);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter step: holds at all-ones when incrementing, at zero when decrementing.
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cur,
    input  logic             inc,
    input  logic             en,
    output logic [CNT_W-1:0] next
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // NOTE: a combinational block assigns every output first so no path can infer a latch.
    always_comb begin
        next = cur;
        if (en) begin
            if (inc) begin
                if (cur != CNT_MAX) next = cur + CNT_W'(1);
            end else begin
                if (cur != '0) next = cur - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// a zero-latency lookup port, a resolve/update port and wrap-around statistics.
module branch_predictor
    import bp_defs::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_W-1:0]     lookup_pc,
    output logic                pred_taken,
    output logic [TARGET_W-1:0] pred_target,
    input  logic                upd_valid,
    input  logic [PC_W-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic [TARGET_W-1:0] upd_target,
    input  logic                upd_uncond,
    input  logic                upd_mispredict,
    output logic [STAT_W-1:0]   stat_updates,
    output logic [STAT_W-1:0]   stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - PC_ALIGN;
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_alloc(CNT_W));

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [TARGET_W-1:0] target;
        logic                uncond;
        logic [CNT_W-1:0]    cnt;
    } entry_t;

    entry_t [ENTRIES-1:0] table_q;
    entry_t               lk_entry;
    entry_t               up_entry;
    entry_t               entry_d;
    logic                 entry_we;
    logic [IDX_W-1:0]     lk_idx;
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic [TAG_W-1:0]     up_tag;
    logic                 lk_hit;
    logic                 up_hit;
    logic [CNT_W-1:0]     cnt_next;
    logic [STAT_W-1:0]    stat_upd_q;
    logic [STAT_W-1:0]    stat_mis_q;

    assign lk_idx   = IDX_W'(pc_index(lookup_pc, IDX_W));
    assign lk_tag   = TAG_W'(pc_tag(lookup_pc, IDX_W));
    assign up_idx   = IDX_W'(pc_index(upd_pc, IDX_W));
    assign up_tag   = TAG_W'(pc_tag(upd_pc, IDX_W));
    assign lk_entry = table_q[lk_idx];
    assign up_entry = table_q[up_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

    // Reads come straight from the flops, so a same-index update is seen only after the edge.
    assign pred_taken  = lk_hit && (lk_entry.uncond || lk_entry.cnt[CNT_W-1]);
    assign pred_target = pred_taken ? lk_entry.target : lookup_pc + TARGET_W'(4);

    sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cur  (up_entry.cnt),
        .inc  (upd_taken),
        .en   (1'b1),
        .next (cnt_next)
    );

    always_comb begin
        entry_d  = up_entry;
        entry_we = 1'b0;
        if (upd_valid) begin
            if (up_hit) begin
                entry_we    = 1'b1;
                entry_d.cnt = cnt_next;
                if (upd_taken) begin
                    entry_d.target = upd_target;
                    entry_d.uncond = upd_uncond;
                end
            end else if (upd_taken) begin
                entry_we = 1'b1;
                entry_d  = '{valid: 1'b1, tag: up_tag, target: upd_target,
                             uncond: upd_uncond, cnt: CNT_ALLOC};
            end
        end
    end

    // State advances on the falling edge to line up with the pipeline stage registers.
    // NOTE: the table is built from flops rather than RAM so the whole array can clear asynchronously.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                                uncond: 1'b0, cnt: CNT_W'(CNT_RESET)};
            end
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (entry_we) table_q[up_idx] <= entry_d;
            if (upd_valid) begin
                stat_upd_q <= stat_upd_q + STAT_W'(1);
                if (upd_mispredict) stat_mis_q <= stat_mis_q + STAT_W'(1);
            end
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against an array-based behavioural model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CALLOC  = 1 << (CNT_W - 1);

    logic              clk;
    logic              reset;
    logic [31:0]       lookup_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_uncond;
    logic              upd_mispredict;
    logic [STAT_W-1:0] stat_updates;
    logic [STAT_W-1:0] stat_mispredicts;

    branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_uncond       (upd_uncond),
        .upd_mispredict   (upd_mispredict),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic        taken;
        logic [31:0] target;
        int          su;
        int          sm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    bit          m_valid  [ENTRIES];
    longint      m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    bit          m_uncond [ENTRIES];
    int          m_cnt    [ENTRIES];
    int          m_su;
    int          m_sm;

    function automatic int idx_of(logic [31:0] pc);
        return int'((longint'(pc) / 4) % ENTRIES);
    endfunction

    function automatic longint tag_of(logic [31:0] pc);
        return longint'(pc) / (4 * ENTRIES);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_uncond[i] = 0; m_cnt[i] = 0;
        end
        m_su = 0;
        m_sm = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input logic unc, input logic mis);
        int i;
        i = idx_of(pc);
        m_su = (m_su + 1) % (1 << STAT_W);
        if (mis) m_sm = (m_sm + 1) % (1 << STAT_W);
        if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
            m_cnt[i] = tk ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                          : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (tk) begin
                m_target[i] = tgt;
                m_uncond[i] = unc;
            end
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt;
            m_uncond[i] = unc; m_cnt[i] = CALLOC;
        end
    endtask

    task automatic cycle(input logic rst_v, input logic [31:0] lpc, input logic v,
                         input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                         input logic unc, input logic mis);
        exp_t e;
        int   i;
        @(posedge clk);
        reset = rst_v; lookup_pc = lpc; upd_valid = v; upd_pc = upc;
        upd_taken = tk; upd_target = tgt; upd_uncond = unc; upd_mispredict = mis;
        if (!rst_v) model_clear();
        i = idx_of(lpc);
        e.step   = step;
        e.taken  = m_valid[i] && m_tag[i] == tag_of(lpc) && (m_uncond[i] || m_cnt[i] >= CALLOC);
        e.target = e.taken ? m_target[i] : lpc + 32'd4;
        e.su     = m_su;
        e.sm     = m_sm;
        exp_q.push_back(e);
        if (rst_v && v) model_update(upc, tk, tgt, unc, mis);
        step++;
    endtask

    task automatic idle(input logic [31:0] lpc);
        cycle(1'b1, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int stp, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, stp, act, req);
        end
    endtask

    // Monitor: outputs settle away from the falling (active) edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred_taken",       e.step, 32'(pred_taken),       32'(e.taken));
                check("pred_target",      e.step, pred_target,           e.target);
                check("stat_updates",     e.step, 32'(stat_updates),     32'(e.su));
                check("stat_mispredicts", e.step, 32'(stat_mispredicts), 32'(e.sm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        reset = 1'b0; lookup_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
        upd_target = '0; upd_uncond = 0; upd_mispredict = 0;
        model_clear();

        // Reset holds everything cleared; a coincident update is discarded.
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
        cycle(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        // First update after release, same-cycle lookup sees the old contents.
        cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        idle(32'h40);
        // Five not-taken updates saturate the counter at zero.
        repeat (5) cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(32'h40);
        // Aliasing: 0x80 replaces 0x40 at index 0.
        cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        cycle(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 1'b0);
        idle(32'h40);
        idle(32'h80);
        // Unconditional jump stays predicted taken through not-taken updates.
        cycle(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 32'h203, 1'b1, 32'h201, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h202);
        // Statistics wrap, then a reset mid-sequence clears them and the table.
        repeat (16) cycle(1'b1, 32'h84, 1'b1, 32'h84, 1'b1, 32'h500, 1'b0, 1'b1);
        idle(32'h84);
        repeat (5) cycle(1'b1, 32'h84, 1'b1, 32'h84, 1'b1, 32'h500, 1'b0, 1'b1);
        cycle(1'b0, 32'h84, 1'b1, 32'h84, 1'b1, 32'h500, 1'b0, 1'b1);
        cycle(1'b1, 32'h84, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h200);
        idle(32'hFFFF_FFFC);

        // Random traffic over a small PC pool so hits, aliases and saturation all occur.
        repeat (600) begin
            pc = ($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pc = $urandom;
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 1) == 0) ? pc : (($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3))),
                  1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
                  $urandom, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", step, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
